// File: rtl/fios_sched_pkg.sv
// Shared types and defaults for the FIOS multiplier scheduler.
// The state encoding is fixed at 3 bits so the state register width stays stable when states are added.
package fios_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ACK   = 3'd3,
        ST_ABORT = 3'd4
    } sched_state_e;

    localparam int DEFAULT_N_REQ   = 4;
    localparam int DEFAULT_TIMEOUT = 256;

endpackage : fios_sched_pkg

// File: rtl/fios_rr_pick.sv
// Combinational round-robin picker: searches from ptr+1 cyclically and returns the first unmasked request.
// The winner is reported both as an index and as a one-hot vector.
module fios_rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] idx,
    output logic [N-1:0]  onehot
);

    logic [N-1:0] eligible;

    assign eligible = req & ~mask;

    // NOTE: every output gets a default before the search loop, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        onehot = '0;
        for (int i = 1; i <= N; i++) begin
            int            cand;
            logic [IW-1:0] cand_idx;
            cand = int'(ptr) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = IW'(cand);
            if (!valid && eligible[cand_idx]) begin
                valid            = 1'b1;
                idx              = cand_idx;
                onehot[cand_idx] = 1'b1;
            end
        end
    end

endmodule : fios_rr_pick

// File: rtl/fios_mm_scheduler.sv
// Round-robin scheduler that shares one FIOS Montgomery multiplier among N_REQ requesters.
// Every output is decoded from registered state, so req_i and mm_done_i never reach an output combinationally.
module fios_mm_scheduler
    import fios_sched_pkg::*;
#(
    parameter int N_REQ   = DEFAULT_N_REQ,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                     clock_i,
    input  logic                     reset_n_i,
    input  logic [N_REQ-1:0]         req_i,
    output logic [N_REQ-1:0]         gnt_o,
    output logic [$clog2(N_REQ)-1:0] sel_o,
    output logic                     busy_o,
    output logic [N_REQ-1:0]         ack_o,
    output logic [N_REQ-1:0]         err_o,
    output logic                     mm_start_o,
    input  logic                     mm_done_i,
    output logic                     mm_reset_o
);

    localparam int SEL_W = $clog2(N_REQ);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0]  WD_MAX  = '1;
    localparam logic [SEL_W-1:0] PTR_RST = SEL_W'(N_REQ - 1);

    sched_state_e     state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [WD_W-1:0]  wd_q, wd_d;

    logic [N_REQ-1:0] sel_oh;
    logic [SEL_W-1:0] pick_ptr;
    logic [N_REQ-1:0] pick_mask;
    logic             pick_valid;
    logic [SEL_W-1:0] pick_idx;
    logic [N_REQ-1:0] pick_oh;

    assign sel_oh = N_REQ'(1) << sel_q;

    // In ACK the picker already sees the updated pointer (sel) and skips the requester just served.
    assign pick_ptr  = (state_q == ST_ACK) ? sel_q : ptr_q;
    assign pick_mask = (state_q == ST_ACK) ? sel_oh : '0;

    fios_rr_pick #(
        .N  (N_REQ),
        .IW (SEL_W)
    ) u_pick (
        .req    (req_i),
        .mask   (pick_mask),
        .ptr    (pick_ptr),
        .valid  (pick_valid),
        .idx    (pick_idx),
        .onehot (pick_oh)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        wd_d    = wd_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    sel_d   = pick_idx;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                wd_d    = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A done that coincides with the last watchdog cycle still completes the operation.
                if (mm_done_i) begin
                    state_d = ST_ACK;
                end else if (wd_q == WD_LAST) begin
                    state_d = ST_ABORT;
                end else if (wd_q != WD_MAX) begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_ACK: begin
                ptr_d = sel_q;
                if (pick_valid) begin
                    sel_d   = pick_idx;
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ABORT: begin
                // The multiplier spends this cycle in reset, so nothing is granted until IDLE.
                ptr_d   = sel_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            ptr_q   <= PTR_RST;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            wd_q    <= wd_d;
        end
    end

    assign sel_o      = sel_q;
    assign busy_o     = (state_q != ST_IDLE);
    assign mm_start_o = (state_q == ST_START);
    assign mm_reset_o = (state_q == ST_ABORT);
    assign gnt_o      = ((state_q == ST_START) || (state_q == ST_WAIT)) ? sel_oh : '0;
    assign ack_o      = (state_q == ST_ACK)   ? sel_oh : '0;
    assign err_o      = (state_q == ST_ABORT) ? sel_oh : '0;

endmodule : fios_mm_scheduler

// File: tb/tb_fios_mm_scheduler.sv
// Self-checking bench for fios_mm_scheduler: a table of back-to-back arbitration rounds
// followed by hand-written sequences for stray done, expiry, timeout, dropped request and async reset.
module tb_fios_mm_scheduler;

    localparam int N_REQ   = 4;
    localparam int TIMEOUT = 32;

    logic             clock_i = 1'b0;
    logic             reset_n_i;
    logic [N_REQ-1:0] req_i;
    logic [N_REQ-1:0] gnt_o;
    logic [1:0]       sel_o;
    logic             busy_o;
    logic [N_REQ-1:0] ack_o;
    logic [N_REQ-1:0] err_o;
    logic             mm_start_o;
    logic             mm_done_i;
    logic             mm_reset_o;

    int n_tests = 0;
    int n_fail  = 0;

    fios_mm_scheduler #(
        .N_REQ   (N_REQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock_i    (clock_i),
        .reset_n_i  (reset_n_i),
        .req_i      (req_i),
        .gnt_o      (gnt_o),
        .sel_o      (sel_o),
        .busy_o     (busy_o),
        .ack_o      (ack_o),
        .err_o      (err_o),
        .mm_start_o (mm_start_o),
        .mm_done_i  (mm_done_i),
        .mm_reset_o (mm_reset_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct {
        logic [3:0] req;        // request vector driven before the arbitration edge
        int         delay;      // WAIT cycles before done is presented
        bit         exp_start;  // a new grant is expected after the edge
        logic [1:0] exp_sel;    // expected winner when exp_start is set
    } vec_t;

    vec_t       vecs[12];
    logic [3:0] oh;
    int         n;
    int         starts;
    bit         flag;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next active edge, where registered outputs have settled.
    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic apply_reset();
        reset_n_i = 1'b0;
        req_i     = '0;
        mm_done_i = 1'b0;
        repeat (2) step();
        reset_n_i = 1'b1;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        // Ptr resets to 3, so the first search starts at requester 0.
        vecs[0]  = '{4'b1111, 10, 1'b1, 2'd0};
        vecs[1]  = '{4'b1111, 10, 1'b1, 2'd1};
        vecs[2]  = '{4'b1111, 10, 1'b1, 2'd2};
        vecs[3]  = '{4'b1111, 10, 1'b1, 2'd3};
        vecs[4]  = '{4'b1111, 10, 1'b1, 2'd0};
        vecs[5]  = '{4'b1010,  3, 1'b1, 2'd1};
        vecs[6]  = '{4'b1010,  0, 1'b1, 2'd3};
        vecs[7]  = '{4'b0100,  5, 1'b1, 2'd2};
        vecs[8]  = '{4'b0110,  1, 1'b1, 2'd1};
        vecs[9]  = '{4'b0010,  0, 1'b0, 2'd0};  // only the just-acked requester: no re-grant from ACK
        vecs[10] = '{4'b0010,  7, 1'b1, 2'd1};  // granted again once back in IDLE
        vecs[11] = '{4'b0000,  0, 1'b0, 2'd0};

        reset_n_i = 1'b0;
        req_i     = '0;
        mm_done_i = 1'b0;
        #1;
        check("rst_gnt",   32'(gnt_o), 32'(0));
        check("rst_sel",   32'(sel_o), 32'(0));
        check("rst_busy",  32'(busy_o), 32'(0));
        check("rst_pulse", 32'({ack_o, err_o, mm_start_o, mm_reset_o}), 32'(0));
        repeat (2) step();
        reset_n_i = 1'b1;
        step();

        // Table: each record is one arbitration edge (from IDLE or ACK), then WAIT, done, ACK.
        for (int i = 0; i < 12; i++) begin
            req_i = vecs[i].req;
            step();
            if (vecs[i].exp_start) begin
                oh = 4'b0001 << vecs[i].exp_sel;
                check($sformatf("v%0d_start", i), 32'(mm_start_o), 32'(1));
                check($sformatf("v%0d_sel", i),   32'(sel_o), 32'(vecs[i].exp_sel));
                check($sformatf("v%0d_gnt", i),   32'(gnt_o), 32'(oh));
                step();
                check($sformatf("v%0d_wait_gnt", i),   32'(gnt_o), 32'(oh));
                check($sformatf("v%0d_wait_start", i), 32'(mm_start_o), 32'(0));
                repeat (vecs[i].delay) step();
                mm_done_i = 1'b1;
                step();
                mm_done_i = 1'b0;
                check($sformatf("v%0d_ack", i),     32'(ack_o), 32'(oh));
                check($sformatf("v%0d_ack_gnt", i), 32'(gnt_o), 32'(0));
                check($sformatf("v%0d_ack_err", i), 32'(err_o), 32'(0));
            end else begin
                check($sformatf("v%0d_idle_busy", i),  32'(busy_o), 32'(0));
                check($sformatf("v%0d_idle_start", i), 32'(mm_start_o), 32'(0));
            end
        end

        // Single request: one start pulse, grant held START..WAIT, one-cycle ack.
        apply_reset();
        req_i  = 4'b0001;
        starts = 0;
        flag   = 1'b0;
        step();
        starts += int'(mm_start_o);
        check("single_gnt", 32'(gnt_o), 32'(4'b0001));
        for (int k = 0; k < 20; k++) begin
            step();
            starts += int'(mm_start_o);
            if (gnt_o !== 4'b0001) flag = 1'b1;
        end
        mm_done_i = 1'b1;
        step();
        mm_done_i = 1'b0;
        check("single_ack", 32'(ack_o), 32'(4'b0001));
        req_i = '0;
        step();
        check("single_ack_once", 32'(ack_o), 32'(0));
        check("single_idle",     32'(busy_o), 32'(0));
        check("single_starts",   32'(starts), 32'(1));
        check("single_gnt_held", 32'(flag), 32'(0));

        // Stray done in IDLE and START, then done on the last watchdog cycle.
        apply_reset();
        mm_done_i = 1'b1;
        step();
        mm_done_i = 1'b0;
        check("stray_idle_busy", 32'(busy_o), 32'(0));
        check("stray_idle_ack",  32'(ack_o), 32'(0));
        req_i = 4'b0001;
        step();
        check("stray_start", 32'(mm_start_o), 32'(1));
        mm_done_i = 1'b1;
        step();
        mm_done_i = 1'b0;
        check("stray_start_ack", 32'(ack_o), 32'(0));
        check("stray_start_gnt", 32'(gnt_o), 32'(4'b0001));
        repeat (TIMEOUT - 1) step();
        check("expiry_pre_gnt", 32'(gnt_o), 32'(4'b0001));
        mm_done_i = 1'b1;
        step();
        mm_done_i = 1'b0;
        check("expiry_ack",   32'(ack_o), 32'(4'b0001));
        check("expiry_err",   32'(err_o), 32'(0));
        check("expiry_reset", 32'(mm_reset_o), 32'(0));
        req_i = '0;
        step();
        check("expiry_idle", 32'(busy_o), 32'(0));

        // Timeout: ABORT exactly TIMEOUT cycles after WAIT entry, err and mm_reset for one cycle.
        apply_reset();
        req_i = 4'b0010;
        step();
        check("to_sel", 32'(sel_o), 32'(1));
        step();
        n    = 0;
        flag = 1'b0;
        while (!mm_reset_o && n < TIMEOUT + 8) begin
            step();
            n++;
            if (ack_o !== 4'b0000) flag = 1'b1;
        end
        check("to_cycles",  32'(n), 32'(TIMEOUT));
        check("to_err",     32'(err_o), 32'(4'b0010));
        check("to_gnt",     32'(gnt_o), 32'(0));
        check("to_no_ack",  32'(flag), 32'(0));
        step();
        check("to_err_once",   32'(err_o), 32'(0));
        check("to_reset_once", 32'(mm_reset_o), 32'(0));
        check("to_idle",       32'(busy_o), 32'(0));
        req_i = '0;
        step();

        // Requester 0 drops its request mid-WAIT: it is still acked, then requester 1 follows.
        apply_reset();
        req_i = 4'b0011;
        step();
        check("drop_sel0", 32'(sel_o), 32'(0));
        step();
        req_i = 4'b0010;
        repeat (4) step();
        mm_done_i = 1'b1;
        step();
        mm_done_i = 1'b0;
        check("drop_ack", 32'(ack_o), 32'(4'b0001));
        step();
        check("drop_next_sel", 32'(sel_o), 32'(1));
        check("drop_next_gnt", 32'(gnt_o), 32'(4'b0010));
        step();
        mm_done_i = 1'b1;
        step();
        mm_done_i = 1'b0;
        check("drop_next_ack", 32'(ack_o), 32'(4'b0010));
        req_i = '0;
        step();
        check("drop_idle", 32'(busy_o), 32'(0));

        // Asynchronous reset mid-WAIT clears outputs without waiting for an edge.
        apply_reset();
        req_i = 4'b0100;
        step();
        step();
        check("arst_pre_gnt", 32'(gnt_o), 32'(4'b0100));
        #2;
        reset_n_i = 1'b0;
        #1;
        check("arst_gnt",   32'(gnt_o), 32'(0));
        check("arst_busy",  32'(busy_o), 32'(0));
        check("arst_sel",   32'(sel_o), 32'(0));
        check("arst_pulse", 32'({ack_o, err_o, mm_start_o, mm_reset_o}), 32'(0));
        req_i = 4'b1111;
        step();
        reset_n_i = 1'b1;
        step();
        check("arst_prio_gnt", 32'(gnt_o), 32'(4'b0001));
        req_i = '0;
        step();
        mm_done_i = 1'b1;
        step();
        mm_done_i = 1'b0;
        check("arst_ack", 32'(ack_o), 32'(4'b0001));
        step();
        check("arst_idle", 32'(busy_o), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_fios_mm_scheduler
